// File: rtl/async_arb_pkg.sv
// ============================================================================
// async_arb_pkg : shared types and width helpers for the async request arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

package async_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } arb_state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) r++;
      return r;
   endfunction

   // Hold counter must represent TIMEOUT itself (saturation value); never zero width.
   function automatic int cnt_width(input int timeout);
      int w;
      w = clog2(timeout + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/async_req_arbiter_sync.sv
// ============================================================================
// async_req_arbiter_sync : multi-flop synchronizer for one asynchronous bit
// Revision 1.0
// ============================================================================
`default_nettype none

module async_req_arbiter_sync #(
   parameter int   STAGES      = 2,
   parameter logic RESET_VALUE = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_chain;

   always_ff @(posedge clk) begin
      if (rst) r_chain <= {STAGES{RESET_VALUE}};
      else     r_chain <= {r_chain[STAGES-2:0], i_d};
   end

   assign o_q = r_chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/async_req_arbiter.sv
// ============================================================================
// async_req_arbiter : round-robin arbiter for asynchronous 4-phase requesters
//                     with a hold-timeout watchdog and per-requester lockout
// Revision 1.0
// ============================================================================
`default_nettype none

module async_req_arbiter
   import async_arb_pkg::*;
#(
   parameter  int N_REQ       = 4,
   parameter  int SYNC_STAGES = 2,
   parameter  int TIMEOUT     = 256,
   localparam int IDW         = (clog2(N_REQ) < 1) ? 1 : clog2(N_REQ)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [N_REQ-1:0] req_async,
   output logic [N_REQ-1:0] ack,
   output logic             grant_valid,
   output logic [IDW-1:0]   grant_id,
   output logic             timeout_p,
   output logic [N_REQ-1:0] lockout
);

   localparam int             CNT_W      = cnt_width(TIMEOUT);
   localparam logic [CNT_W-1:0] c_cnt_max  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] c_cnt_last = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

   arb_state_t       r_state, w_state_nxt;
   logic [IDW-1:0]   r_ptr, w_ptr_nxt;
   logic [IDW-1:0]   r_id, w_id_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [N_REQ-1:0] r_ack, w_ack_nxt;
   logic [N_REQ-1:0] r_lockout, w_lockout_nxt;
   logic             r_timeout_p, w_timeout_nxt;
   logic [N_REQ-1:0] w_req_s;
   logic [N_REQ-1:0] w_elig;
   logic [IDW-1:0]   w_pick;
   logic             w_sync_rst;

   assign w_sync_rst = ~reset_n;

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_sync
      async_req_arbiter_sync #(
         .STAGES      (SYNC_STAGES),
         .RESET_VALUE (1'b0)
      ) u_sync (
         .clk (clk),
         .rst (w_sync_rst),
         .i_d (req_async[gi]),
         .o_q (w_req_s[gi])
      );
   end

   // First eligible index at or after ptr, wrapping.
   function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] elig,
                                              input logic [IDW-1:0]   ptr);
      logic [IDW-1:0] pick;
      logic           found;
      int             idx;
      pick  = '0;
      found = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!found && elig[IDW'(idx)]) begin
            pick  = IDW'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] id);
      return (int'(id) == N_REQ - 1) ? '0 : id + 1'b1;
   endfunction

   assign w_elig = w_req_s & ~r_lockout;
   assign w_pick = rr_pick(w_elig, r_ptr);

   always_comb begin
      w_state_nxt   = r_state;
      w_ptr_nxt     = r_ptr;
      w_id_nxt      = r_id;
      w_cnt_nxt     = r_cnt;
      w_ack_nxt     = r_ack;
      w_timeout_nxt = 1'b0;
      w_lockout_nxt = r_lockout & w_req_s;
      case (r_state)
         IDLE: begin
            if (|w_elig) begin
               w_ack_nxt         = '0;
               w_ack_nxt[w_pick] = 1'b1;
               w_id_nxt          = w_pick;
               w_cnt_nxt         = '0;
               w_state_nxt       = GRANT;
            end
         end
         GRANT: begin
            if (r_cnt != c_cnt_max) w_cnt_nxt = r_cnt + 1'b1;
            // Owner release is checked first so it wins over a coincident timeout.
            if (!w_req_s[r_id]) begin
               w_ack_nxt   = '0;
               w_id_nxt    = '0;
               w_ptr_nxt   = next_idx(r_id);
               w_state_nxt = RELEASE;
            end else if ((TIMEOUT != 0) && (r_cnt == c_cnt_last)) begin
               w_ack_nxt           = '0;
               w_id_nxt            = '0;
               w_lockout_nxt[r_id] = 1'b1;
               w_timeout_nxt       = 1'b1;
               w_ptr_nxt           = next_idx(r_id);
               w_state_nxt         = RELEASE;
            end
         end
         RELEASE: begin
            w_ack_nxt   = '0;
            w_id_nxt    = '0;
            w_state_nxt = IDLE;
         end
         default: begin
            w_ack_nxt   = '0;
            w_id_nxt    = '0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_ptr       <= '0;
         r_id        <= '0;
         r_cnt       <= '0;
         r_ack       <= '0;
         r_timeout_p <= 1'b0;
         r_lockout   <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_ptr       <= w_ptr_nxt;
         r_id        <= w_id_nxt;
         r_cnt       <= w_cnt_nxt;
         r_ack       <= w_ack_nxt;
         r_timeout_p <= w_timeout_nxt;
         r_lockout   <= w_lockout_nxt;
      end
   end

   assign ack         = r_ack;
   assign grant_valid = |r_ack;
   assign grant_id    = r_id;
   assign timeout_p   = r_timeout_p;
   assign lockout     = r_lockout;

endmodule

`default_nettype wire

// File: tb/tb_async_req_arbiter.sv
// ============================================================================
// tb_async_req_arbiter : directed self-checking bench for async_req_arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_async_req_arbiter;

   logic       clk;
   logic       reset_n;
   logic [3:0] req_a, req_b;
   logic [3:0] ack_a, ack_b;
   logic       gv_a, gv_b;
   logic [1:0] gid_a, gid_b;
   logic       tp_a, tp_b;
   logic [3:0] lo_a, lo_b;

   int n_checks = 0;
   int n_errors = 0;
   int tp_cnt_b = 0;
   int rr_seq [6] = '{0, 1, 3, 0, 1, 3};

   async_req_arbiter u_dut_a (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_async   (req_a),
      .ack         (ack_a),
      .grant_valid (gv_a),
      .grant_id    (gid_a),
      .timeout_p   (tp_a),
      .lockout     (lo_a)
   );

   async_req_arbiter #(.N_REQ(4), .SYNC_STAGES(2), .TIMEOUT(8)) u_dut_b (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_async   (req_b),
      .ack         (ack_b),
      .grant_valid (gv_b),
      .grant_id    (gid_b),
      .timeout_p   (tp_b),
      .lockout     (lo_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (tp_b === 1'b1) tp_cnt_b++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Samples on negedges until the selected ack equals target; returns samples taken.
   task automatic wait_ack(input logic sel_b, input logic [3:0] target, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (((sel_b ? ack_b : ack_a) !== target) && (n < 20));
   endtask

   initial begin
      int n;
      int hi;
      int nz;
      int k;
      int low;
      int owner;

      // Reset held with all requests high
      reset_n = 1'b0;
      req_a   = 4'b1111;
      req_b   = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("rst_ack", ack_a, 0);
         check_eq("rst_gv", gv_a, 0);
         check_eq("rst_lockout", lo_a, 0);
      end
      reset_n = 1'b1;
      wait_ack(1'b0, 4'b0001, n);
      check_eq("rst_first_latency", n, 3);
      check_eq("rst_first_id", gid_a, 0);
      req_a = 4'b0000;
      wait_ack(1'b0, 4'b0000, n);
      check_eq("rst_first_drop", n, 3);
      tick(3);

      // Single requester 2
      req_a = 4'b0100;
      wait_ack(1'b0, 4'b0100, n);
      check_eq("single_rise_latency", n, 3);
      check_eq("single_id", gid_a, 2);
      check_eq("single_gv", gv_a, 1);
      tick(7);
      check_eq("single_hold", ack_a, 4'b0100);
      req_a = 4'b0000;
      wait_ack(1'b0, 4'b0000, n);
      check_eq("single_fall_latency", n, 3);
      check_eq("single_id_idle", gid_a, 0);
      check_eq("single_gv_idle", gv_a, 0);

      // Round-robin with 4-cycle owner drops
      reset_n = 1'b0;
      tick(2);
      reset_n = 1'b1;
      req_a   = 4'b1011;
      wait_ack(1'b0, 4'b0001, n);
      check_eq("rr_first_latency", n, 3);
      for (int g = 0; g < 6; g++) begin
         owner = rr_seq[g];
         check_eq("rr_ack", ack_a, 32'(1) << owner);
         check_eq("rr_id", gid_a, owner);
         req_a[owner] = 1'b0;
         k   = 0;
         low = 0;
         while (k < 30) begin
            @(negedge clk);
            k++;
            if (k == 4) req_a[owner] = 1'b1;
            if (ack_a == 4'b0000) low++;
            else if (low > 0) break;
         end
         req_a[owner] = 1'b1;
         check_eq("rr_gap", low, 2);
      end
      req_a = 4'b0000;
      wait_ack(1'b0, 4'b0000, n);
      tick(3);

      // Timeout on DUT B: requester 1 never releases
      req_b = 4'b0010;
      wait_ack(1'b1, 4'b0010, n);
      check_eq("to_rise_latency", n, 3);
      check_eq("to_id", gid_b, 1);
      hi = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ack_b[1]) hi++;
         else break;
      end
      check_eq("to_hold_cycles", hi, 8);
      check_eq("to_pulse", tp_b, 1);
      check_eq("to_lockout", lo_b, 4'b0010);
      check_eq("to_gv_low", gv_b, 0);
      @(negedge clk);
      check_eq("to_pulse_one_cycle", tp_b, 0);
      nz = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (ack_b != 4'b0000) nz++;
      end
      check_eq("to_no_regrant", nz, 0);
      check_eq("to_lockout_held", lo_b, 4'b0010);
      check_eq("to_pulse_count", tp_cnt_b, 1);
      req_b = 4'b0000;
      tick(3);
      check_eq("to_lockout_clear", lo_b, 4'b0000);
      tick(3);

      // Release on the timeout cycle: release must win (ptr now 2)
      req_b = 4'b0100;
      wait_ack(1'b1, 4'b0100, n);
      check_eq("col_rise_latency", n, 3);
      tick(5);
      req_b = 4'b0000;
      tick(2);
      check_eq("col_ack_s7", ack_b, 4'b0100);
      @(negedge clk);
      check_eq("col_ack_s8", ack_b, 4'b0000);
      check_eq("col_no_pulse", tp_b, 0);
      check_eq("col_no_lockout", lo_b, 4'b0000);
      tick(2);
      check_eq("col_pulse_count", tp_cnt_b, 1);

      // Reset mid-GRANT; move ptr away from 0 first
      req_a = 4'b0010;
      wait_ack(1'b0, 4'b0010, n);
      check_eq("mid_prep_grant1", ack_a, 4'b0010);
      req_a = 4'b0000;
      wait_ack(1'b0, 4'b0000, n);
      tick(2);
      req_a = 4'b1000;
      wait_ack(1'b0, 4'b1000, n);
      check_eq("mid_grant3", gid_a, 3);
      reset_n = 1'b0;
      @(negedge clk);
      check_eq("mid_rst_ack", ack_a, 0);
      check_eq("mid_rst_gv", gv_a, 0);
      check_eq("mid_rst_id", gid_a, 0);
      tick(1);
      reset_n = 1'b1;
      wait_ack(1'b0, 4'b1000, n);
      check_eq("mid_regrant_latency", n, 3);

      // Pointer must restart at 0 after reset
      reset_n = 1'b0;
      req_a   = 4'b1001;
      tick(2);
      reset_n = 1'b1;
      tick(3);
      check_eq("rst_ptr_zero", ack_a, 4'b0001);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
